// File: rtl/grey_count_ctrl.sv
// Two-digit grey decade counter controller: merges run tick, event and STEP requests into at most one
// advance per clock with a 3-deep backlog. Define GREY_DOWN_EN to add the i_down count-direction input.
module grey_count_ctrl #(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned PS_W     = 8
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  input  logic [1:0] i_cmd,
  output logic       o_cmd_ready,
  input  logic       i_evt,
`ifdef GREY_DOWN_EN
  input  logic       i_down,
`endif
  output logic [4:0] o_ones,
  output logic [4:0] o_tens,
  output logic       o_run,
  output logic       o_busy,
  output logic       o_wrap,
  output logic       o_drop
);

  typedef enum logic [1:0] {StIdle, StRun, StClr} state_e;

  localparam logic [1:0]      CmdRun   = 2'b00;
  localparam logic [1:0]      CmdStop  = 2'b01;
  localparam logic [1:0]      CmdStep  = 2'b10;
  localparam logic [1:0]      CmdClear = 2'b11;
  localparam logic [PS_W-1:0] PsLast   = PS_W'(PRESCALE - 1);

  function automatic logic [4:0] code_up(input logic [4:0] c);
    case (c)
      5'b00000: code_up = 5'b00001;
      5'b00001: code_up = 5'b00011;
      5'b00011: code_up = 5'b00010;
      5'b00010: code_up = 5'b00110;
      5'b00110: code_up = 5'b00100;
      5'b00100: code_up = 5'b01100;
      5'b01100: code_up = 5'b01000;
      5'b01000: code_up = 5'b11000;
      5'b11000: code_up = 5'b10000;
      default:  code_up = 5'b00000;
    endcase
  endfunction

  function automatic logic [4:0] code_dn(input logic [4:0] c);
    case (c)
      5'b00000: code_dn = 5'b10000;
      5'b10000: code_dn = 5'b11000;
      5'b11000: code_dn = 5'b01000;
      5'b01000: code_dn = 5'b01100;
      5'b01100: code_dn = 5'b00100;
      5'b00100: code_dn = 5'b00110;
      5'b00110: code_dn = 5'b00010;
      5'b00010: code_dn = 5'b00011;
      5'b00011: code_dn = 5'b00001;
      default:  code_dn = 5'b00000;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [PS_W-1:0] ps_q, ps_d;
  logic [1:0]      backlog_q, backlog_d;
  logic [4:0]      ones_q, ones_d, tens_q, tens_d;
  logic            wrap_q, wrap_d, drop_q, drop_d, busy_q;
  logic            cmd_acc, tick, step_req, down;
  logic [2:0]      total;

`ifdef GREY_DOWN_EN
  assign down = i_down;
`else
  assign down = 1'b0;
`endif

  assign o_cmd_ready = (state_q != StClr);
  assign cmd_acc     = i_cmd_valid && o_cmd_ready;
  assign tick        = (state_q == StRun) && (ps_q == PsLast);
  assign step_req    = cmd_acc && (i_cmd == CmdStep);
  assign total       = 3'(backlog_q) + 3'(tick) + 3'(i_evt) + 3'(step_req);

  always_comb begin
    state_d   = state_q;
    ps_d      = ps_q;
    backlog_d = backlog_q;
    ones_d    = ones_q;
    tens_d    = tens_q;
    wrap_d    = 1'b0;
    drop_d    = 1'b0;
    if (state_q == StRun) begin
      ps_d = tick ? '0 : ps_q + PS_W'(1);
    end
    if (state_q == StClr) begin
      // Everything arriving during the clear cycle is thrown away.
      state_d = StIdle;
      drop_d  = (total != 3'd0);
    end else if (cmd_acc && (i_cmd == CmdClear)) begin
      state_d   = StClr;
      ps_d      = '0;
      backlog_d = 2'd0;
      ones_d    = 5'b00000;
      tens_d    = 5'b00000;
      drop_d    = tick || i_evt;
    end else begin
      if (cmd_acc) begin
        case (i_cmd)
          CmdRun: begin
            state_d = StRun;
            ps_d    = '0;
          end
          CmdStop: begin
            state_d = StIdle;
            ps_d    = '0;
          end
          default: ;
        endcase
      end
      if (total != 3'd0) begin
        backlog_d = (total > 3'd4) ? 2'd3 : 2'(total - 3'd1);
        drop_d    = (total > 3'd4);
        if (down) begin
          if (ones_q == 5'b00000) begin
            ones_d = 5'b10000;
            if (tens_q == 5'b00000) begin
              tens_d = 5'b10000;
              wrap_d = 1'b1;
            end else begin
              tens_d = code_dn(tens_q);
            end
          end else begin
            ones_d = code_dn(ones_q);
          end
        end else begin
          if (ones_q == 5'b10000) begin
            ones_d = 5'b00000;
            if (tens_q == 5'b10000) begin
              tens_d = 5'b00000;
              wrap_d = 1'b1;
            end else begin
              tens_d = code_up(tens_q);
            end
          end else begin
            ones_d = code_up(ones_q);
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      ps_q      <= '0;
      backlog_q <= 2'd0;
      ones_q    <= 5'b00000;
      tens_q    <= 5'b00000;
      wrap_q    <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ps_q      <= ps_d;
      backlog_q <= backlog_d;
      ones_q    <= ones_d;
      tens_q    <= tens_d;
      wrap_q    <= wrap_d;
      drop_q    <= drop_d;
      busy_q    <= (backlog_d != 2'd0);
    end
  end

  assign o_ones = ones_q;
  assign o_tens = tens_q;
  assign o_run  = (state_q == StRun);
  assign o_busy = busy_q;
  assign o_wrap = wrap_q;
  assign o_drop = drop_q;

endmodule
